fib_pair_serializer: RTL
========================

// Module: fib_pair_serializer
//
// PURPOSE
//   Downstream stage of the double-rate Fibonacci generator.
//   - Accepts one pair of WIDTH-bit numbers per transfer: {first, second}.
//   - Buffers the pairs in a small FIFO.
//   - Emits one number per cycle on a valid/ready stream, first then second.
//   - Tracks how many words have been emitted.
//   - Raises a sticky flag when the sequence wraps modulo 2^WIDTH.
//   Use: a single-rate consumer (checker, display, UART) can drain the
//   two-per-cycle producer.
//
// PARAMETERS
//   WIDTH  16  data width of each number
//   DEPTH  4   FIFO depth in pairs; power of 2, >= 2
//   CNT_W  16  width of emitted-word counter (wraps modulo 2^CNT_W)
//
// PORTS
//   clk        in   1        clock, all state on posedge
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        upstream pair valid
//   in_ready   out  1        FIFO can accept a pair (= !full)
//   in_first   in   WIDTH    first (earlier) number of pair
//   in_second  in   WIDTH    second (later) number of pair
//   out_valid  out  1        out_data valid (= !empty)
//   out_ready  in   1        downstream accepts out_data
//   out_data   out  WIDTH    current number: head.first if sel==0, else head.second
//   emit_cnt   out  CNT_W    number of words transferred on output
//   wrap_seen  out  1        sticky: an emitted word was < previous emitted word
//
// BEHAVIOUR
//   Reset and handshake
//   - Reset: on rst assertion, asynchronously clear FIFO ptrs/count, sel, emit_cnt,
//     wrap_seen, prev-word valid; resulting outputs: out_valid=0, in_ready=1,
//     out_data=0, emit_cnt=0, wrap_seen=0. Mid-operation reset discards buffered data.
//     rst deassertion is synchronised to clk by the reset source.
//   - Push: in_valid & in_ready -> write {in_first,in_second} at wr_ptr, count+1.
//     in_ready depends only on count (no combinational path from out_ready).
//     When full, no push even if a pop occurs the same cycle.
//   - Latency: pair pushed into empty FIFO at edge N -> out_valid=1 after edge N,
//     with out_data=in_first. No same-cycle bypass.
//   - Pop: out_valid & out_ready:
//     - sel==0 -> sel<=1;
//     - sel==1 -> sel<=0, rd_ptr+1, count-1.
//     A pair is freed only after its second word transfers.
//   - Simultaneous push and final-word pop: count unchanged, both pointers advance.
//   - out_valid=0 -> out_data is don't-care, but holds the last head value.
//     out_valid=1 & !out_ready -> out_data, sel and state are held stable.
//   - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//
//   Counter and wrap flag
//   - emit_cnt increments by 1 per output transfer, modulo 2^CNT_W.
//   - wrap_seen is set on the edge completing a transfer whose word is < the
//     previously transferred word. The first transfer after reset has no compare.
//     Equal words do not set it (1,1). It clears only on rst.
//   - Unsigned arithmetic throughout; no saturation.
//
// TESTING
//   1. Reset with rst pulse between edges -> outputs clear immediately:
//      out_valid=0, in_ready=1, emit_cnt=0, wrap_seen=0.
//   2. out_ready=1; push (1,1),(2,3),(5,8) on consecutive cycles -> out_data
//      1,1,2,3,5,8 on 6 consecutive cycles; emit_cnt=6; wrap_seen=0.
//   3. out_ready=0; push 5 pairs back-to-back -> in_ready=0 after 4th accepted,
//      5th held. Raise out_ready -> 8 words in order, then 5th pair,
//      in_ready=1 again after 2nd word.
//   4. Drop out_ready after first word of (13,21) for 3 cycles -> out_data stays
//      21, out_valid=1, emit_cnt unchanged. Then 21 transfers once.
//   5. Stream (28657,46368),(9489,55857) -> wrap_seen rises on the edge 9489
//      transfers and stays 1 through later words.
//   6. At count=3 with sel=1 and out_ready=1, push one pair -> count stays 3.
//      Assert rst mid-stream -> out_valid=0 at once; after release,
//      push (1,1) -> 1,1 re-emitted.

Source files
------------

// File: rtl/fib_pair_serializer.sv
// fib_pair_serializer: buffers {first, second} number pairs in a small FIFO.
// It emits one word per cycle on a valid/ready stream, first word then second.
// It also counts emitted words and flags when the emitted sequence decreases,
// which happens when the upstream Fibonacci sequence wraps modulo 2^WIDTH.
module fib_pair_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_first,
  input  logic [WIDTH-1:0] in_second,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] emit_cnt,
  output logic             wrap_seen
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {
    SEL_FIRST  = 1'b0,
    SEL_SECOND = 1'b1
  } sel_t;

  logic [WIDTH-1:0] mem_first  [DEPTH];
  logic [WIDTH-1:0] mem_second [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  sel_t             sel;
  sel_t             sel_nxt;
  logic [PTR_W:0]   count_nxt;
  logic [WIDTH-1:0] head_word;
  logic [WIDTH-1:0] prev_word;
  logic             prev_vld;
  logic             push;
  logic             pop;
  logic             pop_last;

  // in_ready is a function of count alone, so it has no path from out_ready.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign pop_last  = pop & (sel == SEL_SECOND);

  assign head_word = (sel == SEL_SECOND) ? mem_second[rd_ptr] : mem_first[rd_ptr];
  // While the FIFO is empty, keep showing the last word that was transferred.
  // This word is cleared on reset, so out_data reads 0 after reset.
  assign out_data  = out_valid ? head_word : prev_word;

  // Next-state logic: word selector toggles on each transfer; occupancy moves by pair.
  always_comb begin
    sel_nxt   = sel;
    count_nxt = count;
    if (pop) begin
      sel_nxt = (sel == SEL_FIRST) ? SEL_SECOND : SEL_FIRST;
    end
    if (push && !pop_last) begin
      count_nxt = count + (PTR_W+1)'(1);
    end else if (!push && pop_last) begin
      count_nxt = count - (PTR_W+1)'(1);
    end
  end

  // FIFO pair storage is data only, so it is written without reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_first[wr_ptr]  <= in_first;
      mem_second[wr_ptr] <= in_second;
    end
  end

  // FIFO control state; the pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sel    <= SEL_FIRST;
    end else begin
      sel   <= sel_nxt;
      count <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_last) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Emitted-word counter and sticky wrap detection against the previous transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      emit_cnt  <= '0;
      wrap_seen <= 1'b0;
      prev_word <= '0;
      prev_vld  <= 1'b0;
    end else if (pop) begin
      emit_cnt  <= emit_cnt + CNT_W'(1);
      prev_word <= head_word;
      prev_vld  <= 1'b1;
      if (prev_vld && (head_word < prev_word)) begin
        wrap_seen <= 1'b1;
      end
    end
  end

endmodule
